// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared single-port memory bus.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one synchronous single-port memory.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating conflict priority; default: load/store always wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstb,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_winner;
  logic                  r_cur_ls;
  logic                  r_cur_we;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_if_rvalid;
  logic                  r_ls_rvalid;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_ls_rdata;

  logic                  w_arb;
  logic                  w_prefer_ls;
  logic                  w_if_gnt;
  logic                  w_ls_gnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_prefer_ls = (r_last_winner == 1'b0);
`else
  // last_winner is still tracked but can never change the outcome here
  assign w_prefer_ls = 1'b1 | r_last_winner;
`endif

  // Grant decision: only outside ACCESS and never while reset is asserted
  always_comb begin
    w_arb    = rstb && (r_state != ACCESS);
    w_ls_gnt = w_arb && bus.ls_req && (!bus.if_req || w_prefer_ls);
    w_if_gnt = w_arb && bus.if_req && !w_ls_gnt;
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.ls_rvalid = r_ls_rvalid;

  // Memory read data arrives during RESP, so the response cycle forwards it directly
  assign bus.if_rdata  = r_if_rvalid ? bus.mem_rdata : r_if_rdata;
  assign bus.ls_rdata  = (r_ls_rvalid && !r_cur_we) ? bus.mem_rdata : r_ls_rdata;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state       <= IDLE;
      r_last_winner <= 1'b1;
      r_cur_ls      <= 1'b0;
      r_cur_we      <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rvalid   <= 1'b0;
      r_ls_rvalid   <= 1'b0;
      r_if_rdata    <= '0;
      r_ls_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
          if (r_if_rvalid) begin
            r_if_rdata <= bus.mem_rdata;
          end
          if (r_ls_rvalid && !r_cur_we) begin
            r_ls_rdata <= bus.mem_rdata;
          end
          if (w_if_gnt || w_ls_gnt) begin
            r_state       <= ACCESS;
            r_last_winner <= w_ls_gnt;
            r_cur_ls      <= w_ls_gnt;
            r_cur_we      <= w_ls_gnt && bus.ls_we;
            r_mem_en      <= 1'b1;
            r_mem_we      <= w_ls_gnt && bus.ls_we;
            r_mem_addr    <= w_ls_gnt ? bus.ls_addr : bus.if_addr;
            if (w_ls_gnt) begin
              r_mem_wdata <= bus.ls_wdata;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_if_rvalid <= !r_cur_ls;
          r_ls_rvalid <= r_cur_ls;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a cycle-scheduled transaction model. Honors MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        mem_loaded = 1'b0;

  function automatic logic [31:0] init_word(int i);
    if (i == 'h10) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Synchronous memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic drive_idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstb = 1'b0;
    drive_idle();
    #2 rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    drive_idle();
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.if_gnt !== 1'b0 || bus.ls_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got if=%b ls=%b expected 0 0", bus.if_gnt, bus.ls_gnt); end
    n_tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_ctl: got en=%b we=%b expected 0 0", bus.mem_en, bus.mem_we); end
    n_tests++; if (bus.if_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rvalid: got if=%b ls=%b expected 0 0", bus.if_rvalid, bus.ls_rvalid); end
    n_tests++; if (bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got if=%h ls=%h expected 0 0", bus.if_rdata, bus.ls_rdata); end
    n_tests++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0 0", bus.mem_addr, bus.mem_wdata); end
    drive_idle();
    rstb = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.if_gnt !== 1'b0 || bus.ls_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: got gnt=%b%b en=%b rv=%b expected all 0",
                         bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.if_rvalid); end
  endtask

  task automatic test_single_fetch();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    @(negedge clk);
    n_tests++; if (bus.if_gnt !== 1'b1 || bus.ls_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fetch_gnt: got if=%b ls=%b expected 1 0", bus.if_gnt, bus.ls_gnt); end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_addr = 32'hFF;
    @(negedge clk);
    n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL fetch_access: got en=%b we=%b addr=%h expected 1 0 00000010",
                         bus.mem_en, bus.mem_we, bus.mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF || bus.mem_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_resp: got rv=%b data=%h en=%b expected 1 deadbeef 0",
                         bus.if_rvalid, bus.if_rdata, bus.mem_en); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_hold: got rv=%b data=%h expected 0 deadbeef", bus.if_rvalid, bus.if_rdata); end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h40; bus.ls_wdata = 32'h12345678;
    @(negedge clk);
    n_tests++; if (bus.ls_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL store_gnt: got ls=%b if=%b expected 1 0", bus.ls_gnt, bus.if_gnt); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL store_access: got en=%b we=%b addr=%h wdata=%h expected 1 1 00000040 12345678",
                         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0 || bus.if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL store_resp: got rv=%b rdata=%h ifrv=%b expected 1 00000000 0",
                         bus.ls_rvalid, bus.ls_rdata, bus.if_rvalid); end
    ref_mem[8'h40] = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (mem[8'h40] !== 32'h12345678 || bus.ls_rvalid !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL store_written: got mem=%h rv=%b we=%b expected 12345678 0 0",
                         mem[8'h40], bus.ls_rvalid, bus.mem_we); end
  endtask

  task automatic test_conflict();
    logic exp_if, exp_ls;
    int   g;
    do_reset();
    g = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 7) begin
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h30;
      end else drive_idle();
      @(negedge clk);
      exp_if = 1'b0; exp_ls = 1'b0;
      if (c % 2 == 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_if = (g % 2 == 0);
        exp_ls = (g % 2 == 1);
`else
        exp_ls = 1'b1;
`endif
        g++;
      end
      n_tests++; if (bus.if_gnt !== exp_if || bus.ls_gnt !== exp_ls) begin
        n_fail++; $display("FAIL conflict_c%0d: got if=%b ls=%b expected %b %b", c, bus.if_gnt, bus.ls_gnt, exp_if, exp_ls); end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic        exp_gnt, exp_rv, exp_en;
    a[0] = 32'h04; a[1] = 32'h08; a[2] = 32'h0C;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      bus.if_req  = (c <= 4);
      bus.if_addr = (c <= 4) ? a[c / 2] : 32'h0;
      @(negedge clk);
      exp_gnt = (c % 2 == 0) && (c <= 4);
      exp_rv  = (c % 2 == 0) && (c >= 2) && (c <= 6);
      exp_en  = (c % 2 == 1) && (c <= 5);
      n_tests++; if (bus.if_gnt !== exp_gnt || bus.if_rvalid !== exp_rv || bus.mem_en !== exp_en) begin
        n_fail++; $display("FAIL b2b_c%0d: got gnt=%b rv=%b en=%b expected %b %b %b",
                           c, bus.if_gnt, bus.if_rvalid, bus.mem_en, exp_gnt, exp_rv, exp_en); end
      if (exp_rv) begin
        n_tests++; if (bus.if_rdata !== ref_mem[a[(c - 2) / 2][7:0]]) begin
          n_fail++; $display("FAIL b2b_data_c%0d: got %h expected %h", c, bus.if_rdata, ref_mem[a[(c - 2) / 2][7:0]]); end
      end
    end
  endtask

  task automatic test_reset_in_access();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h24;
    @(negedge clk);
    n_tests++; if (bus.if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_acc_gnt: got %b expected 1", bus.if_gnt); end
    @(posedge clk); #1;
    drive_idle();
    #1;
    n_tests++; if (bus.mem_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_acc_pre: got mem_en=%b expected 1", bus.mem_en); end
    #1 rstb = 1'b0;
    #1;
    n_tests++; if (bus.mem_en !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_acc_abort: got en=%b rv=%b addr=%h expected 0 0 00000000",
                         bus.mem_en, bus.if_rvalid, bus.mem_addr); end
    @(posedge clk); #1;
    rstb = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h28;
    @(negedge clk);
    n_tests++; if (bus.if_gnt !== 1'b1 || bus.if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_acc_regrant: got gnt=%b rv=%b expected 1 0", bus.if_gnt, bus.if_rvalid); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.if_rvalid !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h28) begin
      n_fail++; $display("FAIL rst_acc_access: got rv=%b en=%b addr=%h expected 0 1 00000028",
                         bus.if_rvalid, bus.mem_en, bus.mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== ref_mem[8'h28]) begin
      n_fail++; $display("FAIL rst_acc_resp: got rv=%b data=%h expected 1 %h", bus.if_rvalid, bus.if_rdata, ref_mem[8'h28]); end
  endtask

  task automatic test_withdrawn();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h2C;
    @(negedge clk);
    n_tests++; if (bus.if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wd_fetch_gnt: got %b expected 1", bus.if_gnt); end
    @(posedge clk); #1;
    drive_idle();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h50; bus.ls_wdata = 32'hCAFEF00D;
    @(negedge clk);
    n_tests++; if (bus.ls_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL wd_access: got lsgnt=%b en=%b we=%b expected 0 1 0", bus.ls_gnt, bus.mem_en, bus.mem_we); end
    @(posedge clk); #1;
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (bus.ls_gnt !== 1'b0 || bus.ls_rvalid !== 1'b0 || bus.if_rvalid !== (c == 0) || bus.mem_en !== 1'b0) begin
        n_fail++; $display("FAIL wd_after_c%0d: got lsgnt=%b lsrv=%b ifrv=%b en=%b expected 0 0 %b 0",
                           c, bus.ls_gnt, bus.ls_rvalid, bus.if_rvalid, bus.mem_en, (c == 0)); end
      @(posedge clk); #1;
    end
    n_tests++; if (mem[8'h50] !== ref_mem[8'h50]) begin
      n_fail++; $display("FAIL wd_no_store: got mem=%h expected %h", mem[8'h50], ref_mem[8'h50]); end
  endtask

  task automatic test_random();
    int          next_arb;
    bit          lw, prefer_ls, if_pend, ls_pend;
    bit          t_valid, t_ls, t_we;
    int          t_g;
    logic [7:0]  t_addr, if_a, ls_a;
    logic [31:0] t_wdata, t_rdata, ls_wd;
    logic        ls_w;
    logic [31:0] h_if_rdata, h_ls_rdata, h_mem_addr, h_mem_wdata;
    logic        e_if_gnt, e_ls_gnt, e_en, e_we, e_if_rv, e_ls_rv;
    logic [31:0] e_if_rdata, e_ls_rdata;
    do_reset();
    next_arb = 0; lw = 1'b1; t_valid = 1'b0; t_g = 0; t_ls = 1'b0; t_we = 1'b0;
    t_addr = '0; t_wdata = '0; t_rdata = '0;
    h_if_rdata = '0; h_ls_rdata = '0; h_mem_addr = '0; h_mem_wdata = '0;
    if_pend = 1'b0; ls_pend = 1'b0; if_a = '0; ls_a = '0; ls_wd = '0; ls_w = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (if_pend) begin if ($urandom_range(0, 9) == 0) if_pend = 1'b0; end
      else if ($urandom_range(0, 1) == 1) begin if_pend = 1'b1; if_a = 8'($urandom_range(0, 255)); end
      if (ls_pend) begin if ($urandom_range(0, 9) == 0) ls_pend = 1'b0; end
      else if ($urandom_range(0, 1) == 1) begin
        ls_pend = 1'b1; ls_a = 8'($urandom_range(0, 255)); ls_w = 1'($urandom_range(0, 1)); ls_wd = $urandom;
      end
      bus.if_req = if_pend; bus.if_addr = 32'(if_a);
      bus.ls_req = ls_pend; bus.ls_addr = 32'(ls_a); bus.ls_we = ls_w; bus.ls_wdata = ls_wd;
      @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prefer_ls = (lw == 1'b0);
`else
      prefer_ls = 1'b1;
`endif
      e_ls_gnt = (c >= next_arb) && ls_pend && (!if_pend || prefer_ls);
      e_if_gnt = (c >= next_arb) && if_pend && !e_ls_gnt;
      e_en     = t_valid && (c == t_g + 1);
      e_we     = e_en && t_we;
      e_if_rv  = t_valid && (c == t_g + 2) && !t_ls;
      e_ls_rv  = t_valid && (c == t_g + 2) && t_ls;
      e_if_rdata = e_if_rv ? t_rdata : h_if_rdata;
      e_ls_rdata = (e_ls_rv && !t_we) ? t_rdata : h_ls_rdata;
      n_tests++; if (bus.if_gnt !== e_if_gnt || bus.ls_gnt !== e_ls_gnt) begin
        n_fail++; $display("FAIL rnd_gnt_c%0d: got if=%b ls=%b expected %b %b", c, bus.if_gnt, bus.ls_gnt, e_if_gnt, e_ls_gnt); end
      n_tests++; if (bus.mem_en !== e_en || bus.mem_we !== e_we) begin
        n_fail++; $display("FAIL rnd_memctl_c%0d: got en=%b we=%b expected %b %b", c, bus.mem_en, bus.mem_we, e_en, e_we); end
      n_tests++; if (bus.mem_addr !== h_mem_addr || bus.mem_wdata !== h_mem_wdata) begin
        n_fail++; $display("FAIL rnd_membus_c%0d: got addr=%h wdata=%h expected %h %h",
                           c, bus.mem_addr, bus.mem_wdata, h_mem_addr, h_mem_wdata); end
      n_tests++; if (bus.if_rvalid !== e_if_rv || bus.if_rdata !== e_if_rdata) begin
        n_fail++; $display("FAIL rnd_if_resp_c%0d: got rv=%b data=%h expected %b %h", c, bus.if_rvalid, bus.if_rdata, e_if_rv, e_if_rdata); end
      n_tests++; if (bus.ls_rvalid !== e_ls_rv || bus.ls_rdata !== e_ls_rdata) begin
        n_fail++; $display("FAIL rnd_ls_resp_c%0d: got rv=%b data=%h expected %b %h", c, bus.ls_rvalid, bus.ls_rdata, e_ls_rv, e_ls_rdata); end
      h_if_rdata = e_if_rdata;
      h_ls_rdata = e_ls_rdata;
      if (e_if_gnt || e_ls_gnt) begin
        t_valid  = 1'b1;
        t_g      = c;
        t_ls     = e_ls_gnt;
        t_we     = e_ls_gnt && ls_w;
        t_addr   = e_ls_gnt ? ls_a : if_a;
        t_wdata  = ls_wd;
        next_arb = c + 2;
        lw       = e_ls_gnt;
        h_mem_addr = 32'(t_addr);
        if (e_ls_gnt) h_mem_wdata = ls_wd;
        if (t_we) ref_mem[t_addr] = t_wdata;
        t_rdata  = ref_mem[t_addr];
        if (e_if_gnt) if_pend = 1'b0;
        if (e_ls_gnt) ls_pend = 1'b0;
      end
    end
    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_fetch();
    test_store();
    test_conflict();
    test_back_to_back();
    test_reset_in_access();
    test_withdrawn();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
